// File: rtl/usb_ep_buf_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_buf_rd_arb_pkg
// Description : Shared constants for the endpoint-buffer read-port arbiter:
//               bus FSM state encoding, owner encoding, default starvation
//               limit.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_ep_buf_rd_arb_pkg;

    // Bus-side read transaction states
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_READ = 2'd2,
        BUS_ACK  = 2'd3
    } bus_state_e;

    // Who owns the read data returning in the next cycle
    localparam logic OWN_TX  = 1'b0;
    localparam logic OWN_BUS = 1'b1;

    // Denied bus cycles tolerated before the bus is forced a slot
    localparam int unsigned STARVE_LIM_DEFAULT = 7;

endpackage
`default_nettype wire

// File: rtl/usb_ep_buf_rd_starve.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_buf_rd_starve
// Description : Saturating count of denied-but-eligible bus cycles. Raises
//               force_o once the count reaches STARVE_LIM so the bus wins the
//               next arbitration against the TX engine.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_buf_rd_starve
    import usb_ep_buf_rd_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic elig_i,
    input  logic gnt_i,
    output logic force_o
);

    localparam int unsigned        c_CW  = $clog2(STARVE_LIM + 1);
    localparam logic [c_CW-1:0]    c_LIM = c_CW'(STARVE_LIM);

    logic [c_CW-1:0] cnt_q;
    logic [c_CW-1:0] cnt_d;

    // Next count: clear on grant, count denied eligible cycles, hold at limit
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_i) begin
            cnt_d = '0;
        end else if (elig_i && (cnt_q != c_LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == c_LIM);

endmodule
`default_nettype wire

// File: rtl/usb_ep_buf_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_buf_rd_arb
// Description : Shares the endpoint buffer's single synchronous read port
//               between the TX engine (fixed high priority, one word per
//               cycle) and the host bus bridge (one word per req/ack).
//               Optional starvation guard: USB_EP_BUF_RD_ARB_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_buf_rd_arb
    import usb_ep_buf_rd_arb_pkg::*;
#(
    parameter int unsigned AW         = 9,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] tx_addr_i,
    input  logic          tx_req_i,
    output logic          tx_gnt_o,
    output logic [DW-1:0] tx_data_o,
    output logic          tx_vld_o,
    input  logic [AW-1:0] bus_addr_i,
    input  logic          bus_req_i,
    output logic          bus_ack_o,
    output logic [DW-1:0] bus_data_o,
    output logic [AW-1:0] mem_rd_addr_0_o,
    output logic          mem_rd_en_0_o,
    input  logic [DW-1:0] mem_rd_data_1_i
);

    if ((STARVE_LIM < 1) || (STARVE_LIM > 255)) begin : g_bad_starve_lim
        $error("usb_ep_buf_rd_arb: STARVE_LIM must be in 1..255");
    end

    bus_state_e    state_q;
    bus_state_e    state_d;
    logic          owner_q;
    logic          rd_vld_q;
    logic [DW-1:0] bus_data_q;

    logic          w_bus_elig;
    logic          w_bus_gnt;
    logic          w_tx_gnt;
    logic          w_force;

    assign w_bus_elig = bus_req_i && ((state_q == BUS_IDLE) || (state_q == BUS_WAIT));

`ifdef USB_EP_BUF_RD_ARB_STARVE_EN
    usb_ep_buf_rd_starve #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .elig_i  (w_bus_elig),
        .gnt_i   (w_bus_gnt),
        .force_o (w_force)
    );
`else
    assign w_force = 1'b0;
`endif

    // Grants are suppressed while reset is asserted so the RAM sees no reads
    assign w_bus_gnt = rst_n && w_bus_elig && (!tx_req_i || w_force);
    assign w_tx_gnt  = rst_n && tx_req_i && !w_bus_gnt;

    assign tx_gnt_o        = w_tx_gnt;
    assign mem_rd_en_0_o   = w_tx_gnt || w_bus_gnt;
    assign mem_rd_addr_0_o = w_bus_gnt ? bus_addr_i : tx_addr_i;

    // Next bus transaction state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (bus_req_i) state_d = w_bus_gnt ? BUS_READ : BUS_WAIT;
            BUS_WAIT: if (w_bus_gnt) state_d = BUS_READ;
            BUS_READ: state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // Bus FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember who issued this cycle's RAM read so the returning word is routed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            owner_q  <= OWN_TX;
        end else begin
            rd_vld_q <= mem_rd_en_0_o;
            owner_q  <= w_bus_gnt ? OWN_BUS : OWN_TX;
        end
    end

    // Capture the bus word when it returns; held until the next bus read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data_q <= '0;
        end else if ((state_q == BUS_READ) && (owner_q == OWN_BUS)) begin
            bus_data_q <= mem_rd_data_1_i;
        end
    end

    assign tx_vld_o   = rd_vld_q && (owner_q == OWN_TX);
    assign tx_data_o  = mem_rd_data_1_i;
    assign bus_ack_o  = (state_q == BUS_ACK);
    assign bus_data_o = bus_data_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_buf_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_ep_buf_rd_arb
// Description : Self-checking bench for usb_ep_buf_rd_arb with a cycle-count
//               reference model, a behavioural RAM and directed plus random
//               stimulus. Honours USB_EP_BUF_RD_ARB_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_ep_buf_rd_arb;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LIM = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] tx_addr = '0;
    logic          tx_req  = 1'b0;
    logic          tx_gnt;
    logic [DW-1:0] tx_data;
    logic          tx_vld;
    logic [AW-1:0] bus_addr = '0;
    logic          bus_req  = 1'b0;
    logic          bus_ack;
    logic [DW-1:0] bus_data;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [DW-1:0] mem_data = '0;

    always #5 clk = ~clk;

    usb_ep_buf_rd_arb #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_LIM (LIM)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_addr_i       (tx_addr),
        .tx_req_i        (tx_req),
        .tx_gnt_o        (tx_gnt),
        .tx_data_o       (tx_data),
        .tx_vld_o        (tx_vld),
        .bus_addr_i      (bus_addr),
        .bus_req_i       (bus_req),
        .bus_ack_o       (bus_ack),
        .bus_data_o      (bus_data),
        .mem_rd_addr_0_o (mem_addr),
        .mem_rd_en_0_o   (mem_en),
        .mem_rd_data_1_i (mem_data)
    );

    // Behavioural synchronous-read RAM with fixed contents
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h100 + i;
        ram[9'h012] = 32'hDEADBEEF;
    end
    always @(posedge clk) if (mem_en) mem_data <= ram[mem_addr];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model (cycle counting) ----------------
    bit starve_en;
    initial begin
`ifdef USB_EP_BUF_RD_ARB_STARVE_EN
        starve_en = 1'b1;
`else
        starve_en = 1'b0;
`endif
    end

    int            m_cyc  = 0;
    bit            m_busy = 0;     // a bus read granted, ack not yet past
    int            m_gcyc = 0;     // cycle of the last bus grant
    logic [AW-1:0] m_gaddr = '0;
    bit            m_ptx  = 0;     // TX granted in previous cycle
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_bdata = '0;
    int            m_deny = 0;
    int            since;
    bit            elig, bgnt, tgnt, forced, eack;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tx_gnt", tx_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_tx_vld", tx_vld, 0);
            chk("rst_bus_ack", bus_ack, 0);
            chk("rst_bus_data", bus_data, 0);
            m_busy = 0; m_ptx = 0; m_deny = 0; m_bdata = '0;
        end else begin
            since  = m_busy ? (m_cyc - m_gcyc) : 1000;
            elig   = bus_req && !(m_busy && since <= 2);
            eack   = m_busy && (since == 2);
            if (eack) m_bdata = ram[m_gaddr];
            forced = starve_en && (m_deny == LIM);
            bgnt   = elig && (!tx_req || forced);
            tgnt   = tx_req && !bgnt;
            chk("m_tx_gnt", tx_gnt, tgnt);
            chk("m_mem_en", mem_en, tgnt | bgnt);
            chk("m_mem_addr", mem_addr, bgnt ? bus_addr : tx_addr);
            chk("m_tx_vld", tx_vld, m_ptx);
            if (m_ptx) chk("m_tx_data", tx_data, ram[m_paddr]);
            chk("m_bus_ack", bus_ack, eack);
            chk("m_bus_data", bus_data, m_bdata);
            m_ptx   = tgnt;
            m_paddr = tx_addr;
            if (bgnt) begin
                m_busy = 1; m_gcyc = m_cyc; m_gaddr = bus_addr; m_deny = 0;
            end else if (elig && m_deny < LIM) begin
                m_deny++;
            end
        end
        m_cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    int  acks;
    bit  ack_prev;

    initial begin
        repeat (3) nxt();
        at_neg();
        chk("reset_bus_ack", bus_ack, 0);
        chk("reset_tx_vld", tx_vld, 0);
        nxt(); rst_n = 1'b1;
        repeat (2) nxt();

        // Bus alone, TX idle
        nxt(); bus_req = 1; bus_addr = 9'h012;
        at_neg(); chk("bus_c0_en", mem_en, 1); chk("bus_c0_addr", mem_addr, 9'h012); chk("bus_c0_ack", bus_ack, 0);
        nxt(); at_neg(); chk("bus_c1_ack", bus_ack, 0);
        nxt(); at_neg(); chk("bus_c2_ack", bus_ack, 1); chk("bus_c2_data", bus_data, 32'hDEADBEEF);
        nxt(); bus_req = 0; at_neg(); chk("bus_c3_ack", bus_ack, 0);

        // TX stream
        for (int n = 0; n < 8; n++) begin
            nxt(); tx_req = 1; tx_addr = AW'(n);
            at_neg(); chk("txs_gnt", tx_gnt, 1);
            if (n > 0) begin
                chk("txs_vld", tx_vld, 1);
                chk("txs_data", tx_data, 32'h100 + n - 1);
            end
        end
        nxt(); tx_req = 0;
        at_neg(); chk("txs_last_vld", tx_vld, 1); chk("txs_last_data", tx_data, 32'h107);
        nxt(); at_neg(); chk("txs_end_vld", tx_vld, 0);

        // Simultaneous arrival
        nxt(); tx_req = 1; tx_addr = 9'h005; bus_req = 1; bus_addr = 9'h020;
        at_neg(); chk("sim_c0_txgnt", tx_gnt, 1); chk("sim_c0_addr", mem_addr, 9'h005);
        nxt(); tx_req = 0;
        at_neg(); chk("sim_c1_en", mem_en, 1); chk("sim_c1_addr", mem_addr, 9'h020);
        nxt(); at_neg(); chk("sim_c2_ack", bus_ack, 0);
        nxt(); at_neg(); chk("sim_c3_ack", bus_ack, 1); chk("sim_c3_data", bus_data, 32'h120);
        nxt(); bus_req = 0;

`ifdef USB_EP_BUF_RD_ARB_STARVE_EN
        // Starvation guard with limit 3
        for (int c = 0; c < 6; c++) begin
            if (c > 0) nxt();
            tx_req = 1; tx_addr = AW'(c); bus_req = 1; bus_addr = 9'h030;
            at_neg();
            if (c < 3) chk("stv_tx_gnt", tx_gnt, 1);
            if (c == 3) begin
                chk("stv_c3_txgnt", tx_gnt, 0);
                chk("stv_c3_addr", mem_addr, 9'h030);
            end
            if (c == 4) chk("stv_c4_txgnt", tx_gnt, 1);
            if (c == 5) begin
                chk("stv_c5_ack", bus_ack, 1);
                chk("stv_c5_data", bus_data, 32'h130);
            end
        end
        nxt(); bus_req = 0; tx_req = 0;
`else
        // Strict priority: bus starves while TX requests
        acks = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) nxt();
            tx_req = 1; tx_addr = AW'(c); bus_req = 1; bus_addr = 9'h030;
            at_neg();
            if (bus_ack) acks++;
        end
        chk("strict_no_ack", acks, 0);
        nxt(); tx_req = 0;
        at_neg(); chk("strict_c100_en", mem_en, 1); chk("strict_c100_addr", mem_addr, 9'h030);
        nxt(); nxt();
        at_neg(); chk("strict_c102_ack", bus_ack, 1); chk("strict_c102_data", bus_data, 32'h130);
        nxt(); bus_req = 0;
`endif
        nxt();

        // Reset in the middle of a bus read
        nxt(); bus_req = 1; bus_addr = 9'h040; tx_req = 0;
        at_neg(); chk("rmr_c0_en", mem_en, 1); chk("rmr_c0_addr", mem_addr, 9'h040);
        nxt(); rst_n = 0;
        at_neg(); chk("rmr_c1_data", bus_data, 0); chk("rmr_c1_en", mem_en, 0);
        nxt(); rst_n = 1;
        at_neg(); chk("rmr_c2_ack", bus_ack, 0); chk("rmr_c2_data", bus_data, 0);
        chk("rmr_c2_en", mem_en, 1); chk("rmr_c2_addr", mem_addr, 9'h040);
        nxt(); nxt();
        at_neg(); chk("rmr_c4_ack", bus_ack, 1); chk("rmr_c4_data", bus_data, 32'h140);
        nxt(); bus_req = 0;

        // Random traffic with occasional resets
        ack_prev = 0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 299) == 0) rst_n = 0;
            tx_req  = ($urandom_range(0, 99) < 60);
            tx_addr = AW'($urandom);
            if (!bus_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    bus_req  = 1;
                    bus_addr = AW'($urandom);
                end
            end else if (ack_prev) begin
                if ($urandom_range(0, 1) == 0) bus_req = 0;
            end
            at_neg();
            ack_prev = bus_ack;
        end

        nxt(); rst_n = 1; tx_req = 0; bus_req = 0;
        repeat (4) nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
